multi_lane_mean: RTL and testbench

- Parametrised successor to the two-way split mean calculator.
- Computes the arithmetic mean of LANES*DEPTH unsigned samples using LANES parallel accumulator lanes, one sample per lane per cycle.
- Combines the lanes as one exact total, not an average of lane averages; final division is truncate or round-half-up, selected by parameter.
- Sits between the sample ROM (array input) and the downstream consumer of mean/done.

---
 rtl/mean_pkg.sv | 16 +
 rtl/mean_lane_acc.sv | 25 ++
 rtl/multi_lane_mean.sv | 137 +++++++++++++
 tb/tb_multi_lane_mean.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mean_pkg.sv
// Shared types and width helpers for the multi-lane mean calculator.
package mean_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        COMBINE,
        DONE
    } state_t;

    // Bits needed to hold the sum of 'count' values that are each 'width' bits wide.
    function automatic int grow_width(input int width, input int count);
        return width + $clog2(count);
    endfunction

endpackage

// File: rtl/mean_lane_acc.sv
// One accumulator lane: sums DEPTH samples. Clearing takes priority over accumulating.
module mean_lane_acc
    import mean_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ACC_W = grow_width(WIDTH, DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] sample,
    output logic [ACC_W-1:0] acc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(sample);
        end
    end

endmodule

// File: rtl/multi_lane_mean.sv
// Mean of LANES*DEPTH unsigned samples using LANES parallel accumulators.
//
// state   | meaning
// IDLE    | waiting for start, ready high
// ACCUM   | each lane adds one sample per cycle, DEPTH cycles
// COMBINE | lanes summed exactly, divided by N, mean registered
// DONE    | done pulse; start here restarts straight into ACCUM
module multi_lane_mean
    import mean_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 2,
    parameter int DEPTH = 16,
    parameter int ROUND = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LANES*DEPTH-1:0][WIDTH-1:0] data_in,
    output logic                              ready,
    output logic                              done,
    output logic [WIDTH-1:0]                  mean
);

    localparam int N     = LANES * DEPTH;
    localparam int LOG2N = $clog2(N);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int ACC_W = grow_width(WIDTH, DEPTH);
    localparam int SUM_W = grow_width(WIDTH, N);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [SUM_W:0]   HALF     = (ROUND != 0) ? (SUM_W + 1)'(N / 2) : '0;

    state_t             state;
    state_t             state_nxt;
    logic               acc_clr;
    logic               acc_en;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc [LANES];
    logic [SUM_W-1:0]   sum;
    logic [SUM_W:0]     rsum;
    logic               unused_bits;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [DEPTH-1:0][WIDTH-1:0] lane_data;

        assign lane_data = data_in[l*DEPTH +: DEPTH];

        mean_lane_acc #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk    (clk),
            .rst    (rst),
            .clr    (acc_clr),
            .en     (acc_en),
            .sample (lane_data[idx]),
            .acc    (acc[l])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_en = 1'b1;
                if (idx == IDX_LAST) begin
                    state_nxt = COMBINE;
                end
            end
            COMBINE: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    acc_clr   = 1'b1;
                    state_nxt = ACCUM;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            idx <= '0;
        end else if (acc_en) begin
            idx <= idx + 1'b1;
        end
    end

    // Exact total across lanes; dividing once avoids average-of-averages error.
    always_comb begin
        sum = '0;
        for (int l = 0; l < LANES; l++) begin
            sum = sum + SUM_W'(acc[l]);
        end
    end

    assign rsum = {1'b0, sum} + HALF;

    // Quotient always fits in WIDTH bits, so the top and fractional bits are dropped.
    assign unused_bits = ^{rsum[SUM_W], rsum[LOG2N-1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            mean <= '0;
        end else if (state == COMBINE) begin
            mean <= rsum[LOG2N +: WIDTH];
        end
    end

    assign ready = (state == IDLE);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_multi_lane_mean.sv
// Scoreboard bench: two 2x16 instances (truncate/round) and two 4x8 instances.
module tb_multi_lane_mean;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst;
    logic             start_a;
    logic             start_b;
    logic [31:0][7:0] data_a;
    logic [31:0][7:0] data_b;
    logic [3:0]       rdy;
    logic [3:0]       dn;
    logic [7:0]       mn [4];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] m;
        int         c;
    } exp_t;

    exp_t sb [4][$];

    multi_lane_mean #(.WIDTH(8), .LANES(2), .DEPTH(16), .ROUND(0)) dut_a_t (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
        .ready(rdy[0]), .done(dn[0]), .mean(mn[0]));
    multi_lane_mean #(.WIDTH(8), .LANES(2), .DEPTH(16), .ROUND(1)) dut_a_r (
        .clk(clk), .rst(rst), .start(start_a), .data_in(data_a),
        .ready(rdy[1]), .done(dn[1]), .mean(mn[1]));
    multi_lane_mean #(.WIDTH(8), .LANES(4), .DEPTH(8), .ROUND(0)) dut_b_t (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_b),
        .ready(rdy[2]), .done(dn[2]), .mean(mn[2]));
    multi_lane_mean #(.WIDTH(8), .LANES(4), .DEPTH(8), .ROUND(1)) dut_b_r (
        .clk(clk), .rst(rst), .start(start_b), .data_in(data_b),
        .ready(rdy[3]), .done(dn[3]), .mean(mn[3]));

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int d = 0; d < 4; d++) begin
            if (dn[d]) begin
                exp_t e;
                if (sb[d].size() == 0) begin
                    total++;
                    $display("FAIL spurious_done dut%0d: done at cycle %0d, expected none", d, cyc);
                end else begin
                    e = sb[d].pop_front();
                    check($sformatf("mean dut%0d", d), int'(mn[d]), int'(e.m));
                    check($sformatf("done_cycle dut%0d", d), cyc, e.c);
                end
            end
        end
    end

    task automatic push_exp(input int d, input logic [7:0] m, input int c);
        exp_t e;
        e.m = m;
        e.c = c;
        sb[d].push_back(e);
    endtask

    // Pulse start for one cycle; done is expected in the cycle after edge k+DEPTH+1.
    task automatic issue(input int pair, input logic [7:0] et, input logic [7:0] er);
        int k;
        int lat;
        @(negedge clk);
        k   = cyc + 1;
        lat = (pair == 0) ? 17 : 9;
        if (pair == 0) start_a = 1'b1;
        else start_b = 1'b1;
        push_exp(2*pair,     et, k + lat);
        push_exp(2*pair + 1, er, k + lat);
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_idle(input int pair);
        int n;
        n = 0;
        while ((sb[2*pair].size() != 0 || sb[2*pair+1].size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL timeout pair%0d: done still pending after %0d cycles, expected done", pair, n);
            sb[2*pair].delete();
            sb[2*pair+1].delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int k;
        int bad;

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        data_a  = '0;
        data_b  = '0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("reset_ready dut%0d", d), int'(rdy[d]), 1);
            check($sformatf("reset_done dut%0d", d), int'(dn[d]), 0);
            check($sformatf("reset_mean dut%0d", d), int'(mn[d]), 0);
        end
        rst = 1'b0;
        @(negedge clk);

        // All samples at full scale.
        for (int i = 0; i < 32; i++) data_a[i] = 8'hFF;
        issue(0, 8'd255, 8'd255);
        wait_idle(0);

        // Ramp 0..31, sum 496.
        for (int i = 0; i < 32; i++) data_a[i] = 8'(i);
        issue(0, 8'd15, 8'd16);
        wait_idle(0);

        // Lanes with different means, total 49.
        for (int i = 0; i < 16; i++) data_a[i] = 8'd1;
        for (int i = 16; i < 32; i++) data_a[i] = 8'd2;
        data_a[20] = 8'd3;
        issue(0, 8'd1, 8'd2);
        wait_idle(0);

        // Second start during ACCUM is ignored.
        for (int i = 0; i < 32; i++) data_a[i] = 8'(i);
        issue(0, 8'd15, 8'd16);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_idle(0);

        // Start held high: restart from DONE, second done 18 cycles later.
        for (int i = 0; i < 16; i++) data_a[i] = 8'd1;
        for (int i = 16; i < 32; i++) data_a[i] = 8'd2;
        data_a[20] = 8'd3;
        @(negedge clk);
        start_a = 1'b1;
        k = cyc + 1;
        push_exp(0, 8'd1, k + 17);
        push_exp(1, 8'd2, k + 17);
        push_exp(0, 8'd1, k + 35);
        push_exp(1, 8'd2, k + 35);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc == k + 19) start_a = 1'b0;
            if (cyc >= k + 17 && cyc <= k + 35 && (rdy[0] || rdy[1])) bad++;
        end
        check("ready_low_b2b", bad, 0);
        wait_idle(0);

        // Reset during ACCUM cycle 5 abandons the computation.
        for (int i = 0; i < 32; i++) data_a[i] = 8'hFF;
        issue(0, 8'd255, 8'd255);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        sb[0].delete();
        sb[1].delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst_ready dut0", int'(rdy[0]), 1);
        check("rst_ready dut1", int'(rdy[1]), 1);
        check("rst_mean dut0", int'(mn[0]), 0);
        check("rst_mean dut1", int'(mn[1]), 0);
        repeat (30) @(negedge clk);

        for (int i = 0; i < 16; i++) data_a[i] = 8'd1;
        for (int i = 16; i < 32; i++) data_a[i] = 8'd2;
        data_a[20] = 8'd3;
        issue(0, 8'd1, 8'd2);
        wait_idle(0);

        // Four lanes of eight: samples i%7, sum 90.
        for (int i = 0; i < 32; i++) data_b[i] = 8'(i % 7);
        issue(1, 8'd2, 8'd3);
        wait_idle(1);

        for (int i = 0; i < 32; i++) data_b[i] = 8'hFF;
        issue(1, 8'd255, 8'd255);
        wait_idle(1);

        repeat (5) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            check($sformatf("pending dut%0d", d), sb[d].size(), 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
